// File: rtl/instr_fetch_pkg.sv
// Shared widths and types for the serial instruction fetch unit.
package instr_fetch_pkg;

   localparam int unsigned INSTR_WIDTH = 9;
   localparam int unsigned FIFO_DEPTH  = 4;
   localparam int unsigned ISSUE_CNT_W = 8;

   typedef logic [INSTR_WIDTH-1:0] instr_t;

endpackage

// File: rtl/instr_fetch_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers and registered full/empty flags.
module sync_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop_i && !empty_q;
      // A push into a full FIFO is only accepted when a pop frees the slot.
      do_push  = push_i && (!full_q || do_pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      empty_d  = (wr_ptr_d == rd_ptr_d);
      full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data_i;
      end
   end

   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/instr_fetch.sv
// Serial-to-parallel instruction loader with FIFO and run/step issue.
// Odd parity per frame is enabled by defining INSTR_FETCH_PARITY_EN.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int unsigned WIDTH = INSTR_WIDTH,
   parameter int unsigned DEPTH = FIFO_DEPTH
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   SDI,
   input  logic                   SVALID,
   input  logic                   RUN,
   input  logic                   STEP,
   output logic [WIDTH-1:0]       INSTRUCTION,
   output logic                   write_en,
   output logic                   EMPTY,
   output logic                   FULL,
   output logic                   OVERFLOW,
   output logic [ISSUE_CNT_W-1:0] ISSUED,
   output logic                   PAR_ERR
);

`ifdef INSTR_FETCH_PARITY_EN
   localparam int unsigned FRAME_BITS = WIDTH + 1;
`else
   localparam int unsigned FRAME_BITS = WIDTH;
`endif
   localparam int unsigned   CNT_W    = $clog2(FRAME_BITS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]       shreg_q, shreg_d;
   logic                   step_q;
   logic [WIDTH-1:0]       instr_q, instr_d;
   logic                   wen_q;
   logic [ISSUE_CNT_W-1:0] issued_q, issued_d;
   logic                   ovf_q, ovf_d;

   logic                   frame_done, push, pop, step_rise;
   logic [WIDTH-1:0]       push_word;
   logic [WIDTH-1:0]       fifo_head;
   logic                   fifo_full, fifo_empty;

`ifdef INSTR_FETCH_PARITY_EN
   logic perr_q, perr_d;
   logic par_fail;
`endif

   always_comb begin
      frame_done = SVALID && (cnt_q == LAST_IDX);
      shreg_d    = SVALID ? {shreg_q[WIDTH-2:0], SDI} : shreg_q;
      cnt_d      = cnt_q;
      if (SVALID) begin
         cnt_d = frame_done ? '0 : cnt_q + CNT_W'(1);
      end

`ifdef INSTR_FETCH_PARITY_EN
      // Data bits are already in shreg_q when the parity bit arrives.
      push_word = shreg_q;
      par_fail  = frame_done && ((^shreg_q ^ SDI) != 1'b1);
      push      = frame_done && !par_fail;
      perr_d    = perr_q | par_fail;
`else
      push_word = {shreg_q[WIDTH-2:0], SDI};
      push      = frame_done;
`endif

      step_rise = STEP & ~step_q;
      pop       = !fifo_empty && (RUN || step_rise);
      ovf_d     = ovf_q | (push && fifo_full && !pop);
      instr_d   = pop ? fifo_head : instr_q;
      issued_d  = issued_q + ISSUE_CNT_W'(pop);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt_q    <= '0;
         shreg_q  <= '0;
         step_q   <= 1'b0;
         instr_q  <= '0;
         wen_q    <= 1'b0;
         issued_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         shreg_q  <= shreg_d;
         step_q   <= STEP;
         instr_q  <= instr_d;
         wen_q    <= pop;
         issued_q <= issued_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef INSTR_FETCH_PARITY_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end
   assign PAR_ERR = perr_q;
`else
   assign PAR_ERR = 1'b0;
`endif

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RESET   (RESET),
      .push_i  (push),
      .data_i  (push_word),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign INSTRUCTION = instr_q;
   assign write_en    = wen_q;
   assign EMPTY       = fifo_empty;
   assign FULL        = fifo_full;
   assign OVERFLOW    = ovf_q;
   assign ISSUED      = issued_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

   localparam int W = 9;

   logic         CLK = 1'b0;
   logic         RESET, SDI, SVALID, RUN, STEP;
   logic [W-1:0] INSTRUCTION;
   logic         write_en, EMPTY, FULL, OVERFLOW, PAR_ERR;
   logic [7:0]   ISSUED;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   instr_fetch dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .SDI         (SDI),
      .SVALID      (SVALID),
      .RUN         (RUN),
      .STEP        (STEP),
      .INSTRUCTION (INSTRUCTION),
      .write_en    (write_en),
      .EMPTY       (EMPTY),
      .FULL        (FULL),
      .OVERFLOW    (OVERFLOW),
      .ISSUED      (ISSUED),
      .PAR_ERR     (PAR_ERR)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic shift_bits(input logic [W-1:0] w, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         SDI    = w[i];
         SVALID = 1'b1;
         tick();
      end
      SVALID = 1'b0;
      SDI    = 1'b0;
   endtask

   task automatic send_par(input logic p);
      SDI    = p;
      SVALID = 1'b1;
      tick();
      SVALID = 1'b0;
      SDI    = 1'b0;
   endtask

   task automatic send_word(input logic [W-1:0] w);
      shift_bits(w, W - 1, 0);
`ifdef INSTR_FETCH_PARITY_EN
      send_par(~^w);
`endif
   endtask

   task automatic test_reset();
      RESET = 1'b1; SDI = 1'b0; SVALID = 1'b0; RUN = 1'b0; STEP = 1'b0;
      #2;
      n_checks++;
      if ({INSTRUCTION, write_en, EMPTY, FULL, OVERFLOW, ISSUED, PAR_ERR} !==
          {9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_vals: got ins=%h we=%b e=%b f=%b ovf=%b iss=%0d pe=%b",
                  INSTRUCTION, write_en, EMPTY, FULL, OVERFLOW, ISSUED, PAR_ERR);
      end
      tick(); tick();
      RESET = 1'b0;
      tick();
      n_checks++;
      if (EMPTY !== 1'b1) begin
         n_fail++; $display("FAIL reset_empty: got %b expected 1", EMPTY);
      end
   endtask

   task automatic test_basic();
      RUN = 1'b1;
      send_word(9'h1A5);
      n_checks++;
      if (write_en !== 1'b0 || EMPTY !== 1'b0) begin
         n_fail++; $display("FAIL basic_queued: got we=%b e=%b expected we=0 e=0", write_en, EMPTY);
      end
      tick();
      n_checks++;
      if (write_en !== 1'b1 || INSTRUCTION !== 9'h1A5 || ISSUED !== 8'd1) begin
         n_fail++;
         $display("FAIL basic_issue: got we=%b ins=%h iss=%0d expected we=1 ins=1a5 iss=1",
                  write_en, INSTRUCTION, ISSUED);
      end
      tick();
      n_checks++;
      if (write_en !== 1'b0 || EMPTY !== 1'b1 || INSTRUCTION !== 9'h1A5) begin
         n_fail++;
         $display("FAIL basic_strobe_len: got we=%b e=%b ins=%h expected we=0 e=1 ins=1a5",
                  write_en, EMPTY, INSTRUCTION);
      end
   endtask

   task automatic test_fill_overflow_step();
      RUN = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         send_word(W'(k));
         if (k == 4) begin
            n_checks++;
            if (FULL !== 1'b1 || OVERFLOW !== 1'b0) begin
               n_fail++; $display("FAIL fill_full: got f=%b ovf=%b expected f=1 ovf=0", FULL, OVERFLOW);
            end
         end
      end
      n_checks++;
      if (OVERFLOW !== 1'b1 || FULL !== 1'b1 || write_en !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_overflow: got ovf=%b f=%b we=%b expected 1 1 0", OVERFLOW, FULL, write_en);
      end
      for (int k = 1; k <= 4; k++) begin
         STEP = 1'b1;
         tick();
         n_checks++;
         if (write_en !== 1'b1 || INSTRUCTION !== W'(k)) begin
            n_fail++;
            $display("FAIL step_issue%0d: got we=%b ins=%h expected we=1 ins=%h",
                     k, write_en, INSTRUCTION, W'(k));
         end
         STEP = 1'b0;
         tick();
      end
      n_checks++;
      if (EMPTY !== 1'b1 || FULL !== 1'b0 || ISSUED !== 8'd5 || PAR_ERR !== 1'b0) begin
         n_fail++;
         $display("FAIL step_drained: got e=%b f=%b iss=%0d pe=%b expected 1 0 5 0",
                  EMPTY, FULL, ISSUED, PAR_ERR);
      end
   endtask

   task automatic test_step_held();
      int           n_we;
      logic [W-1:0] got;
      n_we = 0;
      got  = '0;
      send_word(9'h001);
      send_word(9'h002);
      STEP = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (write_en === 1'b1) begin
            n_we++;
            got = INSTRUCTION;
         end
      end
      STEP = 1'b0;
      tick();
      n_checks++;
      if (n_we != 1 || got !== 9'h001 || ISSUED !== 8'd6 || EMPTY !== 1'b0) begin
         n_fail++;
         $display("FAIL step_held: got issues=%0d ins=%h iss=%0d e=%b expected 1 001 6 0",
                  n_we, got, ISSUED, EMPTY);
      end
   endtask

   task automatic test_reset_mid_op();
      send_word(9'h003);  // FIFO now holds 002, 003
      RESET = 1'b1;
      #2;
      n_checks++;
      if ({INSTRUCTION, write_en, EMPTY, FULL, OVERFLOW, ISSUED} !==
          {9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL reset_async: got ins=%h we=%b e=%b f=%b ovf=%b iss=%0d",
                  INSTRUCTION, write_en, EMPTY, FULL, OVERFLOW, ISSUED);
      end
      tick();
      RESET = 1'b0;
      tick();
      n_checks++;
      if (EMPTY !== 1'b1 || ISSUED !== 8'd0 || write_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got e=%b iss=%0d we=%b expected 1 0 0", EMPTY, ISSUED, write_en);
      end
   endtask

   task automatic test_gaps();
      RUN = 1'b1;
      shift_bits(9'h0FF, 8, 4);
      tick(); tick(); tick();
      shift_bits(9'h0FF, 3, 0);
`ifdef INSTR_FETCH_PARITY_EN
      send_par(~^9'h0FF);
`endif
      tick();
      n_checks++;
      if (write_en !== 1'b1 || INSTRUCTION !== 9'h0FF || ISSUED !== 8'd1) begin
         n_fail++;
         $display("FAIL gaps: got we=%b ins=%h iss=%0d expected we=1 ins=0ff iss=1",
                  write_en, INSTRUCTION, ISSUED);
      end
   endtask

   task automatic test_reset_mid_frame();
      RUN = 1'b1;
      shift_bits(9'h1E0, 8, 5);
      RESET = 1'b1;
      #2;
      RESET = 1'b0;
      send_word(9'h155);
      tick();
      n_checks++;
      if (write_en !== 1'b1 || INSTRUCTION !== 9'h155 || ISSUED !== 8'd1) begin
         n_fail++;
         $display("FAIL reset_mid_frame: got we=%b ins=%h iss=%0d expected we=1 ins=155 iss=1",
                  write_en, INSTRUCTION, ISSUED);
      end
   endtask

`ifdef INSTR_FETCH_PARITY_EN
   task automatic test_parity();
      RUN = 1'b1;
      shift_bits(9'h003, 8, 0);
      send_par(1'b0);
      n_checks++;
      if (PAR_ERR !== 1'b1 || EMPTY !== 1'b1) begin
         n_fail++; $display("FAIL parity_bad: got pe=%b e=%b expected pe=1 e=1", PAR_ERR, EMPTY);
      end
      tick();
      n_checks++;
      if (write_en !== 1'b0) begin
         n_fail++; $display("FAIL parity_no_issue: got we=%b expected 0", write_en);
      end
      shift_bits(9'h003, 8, 0);
      send_par(1'b1);
      tick();
      n_checks++;
      if (write_en !== 1'b1 || INSTRUCTION !== 9'h003 || PAR_ERR !== 1'b1) begin
         n_fail++;
         $display("FAIL parity_good: got we=%b ins=%h pe=%b expected we=1 ins=003 pe=1",
                  write_en, INSTRUCTION, PAR_ERR);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_fill_overflow_step();
      test_step_held();
      test_reset_mid_op();
      test_gaps();
      test_reset_mid_frame();
`ifdef INSTR_FETCH_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Serial instruction loader sitting directly upstream of the accumulator CPU. Deserialises a one-bit instruction stream (pin-limited input) into WIDTH-bit words, buffers them in a small FIFO, and issues them to the CPU as `INSTRUCTION` with a one-cycle `write_en` strobe, either free-running or single-stepped. All logic is in the `CLK` domain.

## Interface
- `WIDTH`, 9, instruction word width in bits.
- `DEPTH`, 4, FIFO depth in words; power of two, ≥2.
- `CLK`  in  1  clock; all state updates on rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `SDI`  in  1  serial data bit, MSB first.
- `SVALID`  in  1  `SDI` is a valid bit this cycle.
- `RUN`  in  1  free-run: issue whenever the FIFO is non-empty.
- `STEP`  in  1  single-step request; the rising edge issues one word.
- `INSTRUCTION`  out  WIDTH  last issued word, held between issues.
- `write_en`  out  1  one-cycle strobe: `INSTRUCTION` is new.
- `EMPTY`  out  1  FIFO empty.
- `FULL`  out  1  FIFO full.
- `OVERFLOW`  out  1  sticky: a completed word was dropped because the FIFO was full.
- `ISSUED`  out  8  count of issued words; wraps from 255 to 0.
- `PAR_ERR`  out  1  sticky parity error; constant 0 when parity is compiled out.

## Operation
- **Deserialiser.** Each cycle with `SVALID=1`: `shreg <= {shreg[WIDTH-2:0], SDI}` and the bit counter increments. `SVALID=0` holds the counter and shift register, so gaps are allowed mid-word.
- **Frame completion.** The frame ends on the last bit (bit index WIDTH-1, or WIDTH with parity). The completed word pushes to the FIFO at that same edge, and the counter returns to 0.
- **Overflow.** If the FIFO is full and no pop occurs that cycle, the word is dropped and `OVERFLOW` is set. It clears only on `RESET`.
- **Push and pop together.**
  - When full, a simultaneous push and pop are both accepted; occupancy is unchanged.
  - When empty, there is no bypass: the pop is not performed, and the pushed word is issued at the earliest one cycle later.
- **Pop condition.** `!EMPTY && (RUN || step_rise)`, where `step_rise = STEP & ~step_q` and `step_q` is registered `STEP`. Holding `STEP` high issues exactly one word.
- **Issue register.** On pop, `INSTRUCTION <=` FIFO head, `write_en <= 1`, and `ISSUED <= ISSUED+1` (mod 256). With no pop, `write_en <= 0` and `INSTRUCTION` holds its value.
- **FIFO.** Read/write pointers are log2(DEPTH)+1 bits. `FULL`/`EMPTY` are decoded from the pointers and registered with them, so they are valid the cycle after the edge that changed occupancy.

## Timing
- **Reset values.** `RESET` clears the bit counter, shift register, FIFO pointers, `step_q`, `INSTRUCTION=0`, `write_en=0`, `EMPTY=1`, `FULL=0`, `OVERFLOW=0`, `ISSUED=0` and `PAR_ERR=0`.
- **Reset mid-frame.** A reset during a frame discards the partial word. Framing restarts at bit 0 on the first `SVALID` after `RESET` deasserts.
- **Latency.** Last bit sampled at edge N → word in FIFO after edge N → with `RUN=1`, `INSTRUCTION` and `write_en=1` after edge N+1. Two edges total.
- **Steady-state throughput.** One word per WIDTH valid bits; the issue side can pop one word per cycle.
- **Step latency.** `STEP` sampled high at edge M with `step_q=0` → `write_en` high after edge M.

## Configuration
- **Macro:** `INSTR_FETCH_PARITY_EN`.
- **Defined:**
  - Frame is WIDTH+1 bits; the final bit is odd parity, so the XOR of all WIDTH+1 bits must equal 1.
  - On mismatch the word is not pushed and `PAR_ERR` is set (sticky).
  - A parity-failed frame arriving while the FIFO is full sets `PAR_ERR` only, not `OVERFLOW`.
- **Undefined:** frame is WIDTH bits, no parity check, and `PAR_ERR` is tied to 0.

## Structure
- **Package `instr_fetch_pkg`:** `INSTR_WIDTH=9`, `FIFO_DEPTH=4`, typedef `instr_t` (logic [INSTR_WIDTH-1:0]) and `ISSUE_CNT_W=8`.
- **Sub-module `sync_fifo`:** parameterised WIDTH/DEPTH, with push/pop, head data, full/empty outputs and a registered storage array. The deserialiser, step edge detect, issue register and counters stay in `instr_fetch`.

## Test plan
- **Reset:** assert `RESET` mid-operation with the FIFO holding 2 words → all outputs at reset values immediately (asynchronous); after release, `EMPTY=1` and `ISSUED=0`.
- **Basic issue:** `RUN=1`, shift `9'h1A5` MSB-first with `SVALID=1` → `INSTRUCTION=9'h1A5`, `write_en` high for exactly one cycle two edges after the last bit, `ISSUED=1`.
- **Fill, overflow and step:** `RUN=0`, load `9'h001` to `9'h005` → `FULL=1` after the 4th word; the 5th is dropped and `OVERFLOW=1`. Then 4 `STEP` pulses → issues `001`, `002`, `003`, `004`, then `EMPTY=1`.
- **Step held high:** hold `STEP` high for 10 cycles with 2 words queued → exactly one issue (`9'h001`); `ISSUED` increments by 1.
- **Gaps and reset mid-frame:**
  - Send `9'h0FF` with `SVALID` low for 3 cycles after bit 4 → `9'h0FF` is issued.
  - Separately, send 4 bits, pulse `RESET`, then send `9'h155` → `9'h155` is issued.
- **Parity (macro defined):** send `9'h003` followed by parity bit 0 → no push, `PAR_ERR=1`. Send `9'h003` with parity bit 1 → issued, `PAR_ERR` stays 1.
